// File: rtl/sp3a_xyq.sv
// sp3a_xyq: ix->iy bridge with a posted-write command queue, in-order blocking reads,
// per-transaction iy timeout and a sticky error flag.
module sp3a_xyq #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int DEPTH = 4,
    parameter int TMO = 255,
    localparam int BW = DW / 8,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          ix_clk,
    input  logic          ix_rst_n,
    input  logic [AW-1:0] ix_addr,
    input  logic [DW-1:0] ix_wdata,
    input  logic [BW-1:0] ix_be,
    input  logic          ix_rd,
    input  logic          ix_req,
    output logic          ix_busy,
    output logic          ix_ack,
    output logic [DW-1:0] ix_rdata,
    output logic          ix_err,
    input  logic          ix_err_clr,
    output logic [LW-1:0] ix_level,
    output logic [AW-1:0] iy_addr,
    output logic [DW-1:0] iy_wdata,
    output logic [BW-1:0] iy_be,
    output logic          iy_rd,
    output logic          iy_req,
    input  logic          iy_busy,
    input  logic          iy_ack,
    input  logic          iy_err,
    input  logic [DW-1:0] iy_rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [15:0] TMO_C = 16'(TMO);

    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nxt;

    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_wdata [DEPTH];
    logic [BW-1:0] q_be [DEPTH];
    logic          q_rd [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [LW-1:0] level;
    logic [15:0]   cnt;
    logic          rd_pend, rd_done, push, issue, pop, fail, empty;

    assign ix_level = level;
    assign ix_busy  = (level == LW'(DEPTH)) | rd_pend;
    assign push     = ix_req & ~ix_busy;
    assign ix_ack   = ix_rst_n & ((push & ~ix_rd) | rd_done);
    assign empty    = (level == '0);

    // An empty queue forwards the command being accepted so iy_req follows the accept cycle
    always_comb begin
        issue     = (state == IDLE) & (~empty | push) & ~iy_busy;
        fail      = (state == WAIT) & (iy_err | ((TMO != 0) & (cnt == TMO_C)));
        pop       = fail | ((state == WAIT) & iy_ack);
        state_nxt = issue ? WAIT : pop ? IDLE : state;
    end

    always_ff @(posedge ix_clk or negedge ix_rst_n) begin
        if (!ix_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_ff @(posedge ix_clk) begin
        if (push) begin
            q_addr[wp]  <= ix_addr;
            q_wdata[wp] <= ix_wdata;
            q_be[wp]    <= ix_be;
            q_rd[wp]    <= ix_rd;
        end
    end

    always_ff @(posedge ix_clk or negedge ix_rst_n) begin
        if (!ix_rst_n) begin
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            cnt      <= '0;
            rd_pend  <= 1'b0;
            rd_done  <= 1'b0;
            iy_addr  <= '0;
            iy_wdata <= '0;
            iy_be    <= '0;
            iy_rd    <= 1'b0;
            iy_req   <= 1'b0;
            ix_rdata <= '0;
            ix_err   <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            level   <= level + LW'(push) - LW'(pop);
            cnt     <= issue ? '0 : cnt + 1'b1;
            rd_pend <= (push & ix_rd) | (rd_pend & ~(pop & iy_rd));
            rd_done <= pop & iy_rd;
            iy_req  <= issue;
            if (issue) begin
                iy_addr  <= empty ? ix_addr : q_addr[rp];
                iy_wdata <= empty ? ix_wdata : q_wdata[rp];
                iy_be    <= empty ? ix_be : q_be[rp];
                iy_rd    <= empty ? ix_rd : q_rd[rp];
            end else if (pop) begin
                iy_be <= '0;
            end
            if (pop & iy_rd) ix_rdata <= fail ? '1 : iy_rdata;
            ix_err <= fail | (ix_err & ~ix_err_clr);
        end
    end
endmodule

// File: tb/tb_sp3a_xyq.sv
// tb_sp3a_xyq: directed checks of sp3a_xyq (TMO=8 main instance, TMO=0 companion).
module tb_sp3a_xyq;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] addr = '0, wdata = '0, iy_rdata_i = '0;
    logic [3:0]  be = '0;
    logic        rd = 1'b0, req = 1'b0, err_clr = 1'b0;
    logic        iy_busy_i = 1'b0, iy_ack_i = 1'b0, iy_err_i = 1'b0;
    logic        busy, ack, err, o_rd, o_req, z_busy, z_ack, z_err, z_rd, z_req;
    logic [31:0] rdata, o_addr, o_wdata, z_rdata, z_addr, z_wdata;
    logic [3:0]  o_be, z_be;
    logic [2:0]  level, z_level;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    sp3a_xyq #(.TMO(8)) dut (
        .ix_clk(clk), .ix_rst_n(rst_n), .ix_addr(addr), .ix_wdata(wdata), .ix_be(be),
        .ix_rd(rd), .ix_req(req), .ix_busy(busy), .ix_ack(ack), .ix_rdata(rdata),
        .ix_err(err), .ix_err_clr(err_clr), .ix_level(level), .iy_addr(o_addr),
        .iy_wdata(o_wdata), .iy_be(o_be), .iy_rd(o_rd), .iy_req(o_req), .iy_busy(iy_busy_i),
        .iy_ack(iy_ack_i), .iy_err(iy_err_i), .iy_rdata(iy_rdata_i)
    );

    sp3a_xyq #(.TMO(0)) dut0 (
        .ix_clk(clk), .ix_rst_n(rst_n), .ix_addr(addr), .ix_wdata(wdata), .ix_be(be),
        .ix_rd(rd), .ix_req(req), .ix_busy(z_busy), .ix_ack(z_ack), .ix_rdata(z_rdata),
        .ix_err(z_err), .ix_err_clr(err_clr), .ix_level(z_level), .iy_addr(z_addr),
        .iy_wdata(z_wdata), .iy_be(z_be), .iy_rd(z_rd), .iy_req(z_req), .iy_busy(iy_busy_i),
        .iy_ack(iy_ack_i), .iy_err(iy_err_i), .iy_rdata(iy_rdata_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 1'b0; rd = 1'b0; err_clr = 1'b0;
        iy_busy_i = 1'b0; iy_ack_i = 1'b0; iy_err_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b1; rd = 1'b0; addr = 32'h10;
        tick();
        tick();
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if ({o_req, o_rd, o_be} !== '0) begin bad++; $display("FAIL rst_iy_ctl got=%b%b%h exp=0", o_req, o_rd, o_be); end
        total++; if ({o_addr, o_wdata} !== '0) begin bad++; $display("FAIL rst_iy_data got=%h %h exp=0", o_addr, o_wdata); end
        total++; if ({level, rdata, err} !== '0) begin bad++; $display("FAIL rst_ix got=%0d %h %b exp=0", level, rdata, err); end
        req = 1'b0;
    endtask

    task automatic test_write();
        do_reset();
        addr = 32'h10; wdata = 32'hA5A5A5A5; be = 4'hF; rd = 1'b0; req = 1'b1;
        #1;
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b exp=1", ack); end
        tick();
        req = 1'b0;
        total++; if (o_req !== 1'b1) begin bad++; $display("FAIL wr_iy_req got=%b exp=1", o_req); end
        total++; if (o_addr !== 32'h10 || o_wdata !== 32'hA5A5A5A5 || o_be !== 4'hF)
            begin bad++; $display("FAIL wr_iy_fields got=%h %h %h exp=10 a5a5a5a5 f", o_addr, o_wdata, o_be); end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL wr_level1 got=%0d exp=1", level); end
        iy_ack_i = 1'b1;
        tick();
        iy_ack_i = 1'b0;
        total++; if (level !== 3'd0) begin bad++; $display("FAIL wr_level0 got=%0d exp=0", level); end
        total++; if (o_req !== 1'b0 || o_be !== 4'h0) begin bad++; $display("FAIL wr_idle got=%b %h exp=0 0", o_req, o_be); end
    endtask

    task automatic test_full();
        int n = 0;
        bit chk = 0;
        do_reset();
        iy_busy_i = 1'b1; rd = 1'b0; be = 4'h3;
        for (int i = 0; i < 4; i++) begin
            addr = 32'h100 + 32'(4 * i); wdata = 32'(i); req = 1'b1;
            #1;
            total++; if (ack !== 1'b1) begin bad++; $display("FAIL full_ack%0d got=%b exp=1", i, ack); end
            tick();
        end
        addr = 32'h200; req = 1'b1;
        #1;
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL full_5th_ack got=%b exp=0", ack); end
        total++; if (level !== 3'd4 || busy !== 1'b1) begin bad++; $display("FAIL full_state got=%0d %b exp=4 1", level, busy); end
        tick();
        req = 1'b0;
        total++; if (level !== 3'd4) begin bad++; $display("FAIL full_ignored got=%0d exp=4", level); end
        iy_busy_i = 1'b0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            iy_ack_i = 1'b0;
            if (n == 1 && !chk) begin
                chk = 1;
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_drop got=%b exp=0", busy); end
            end
            if (o_req) begin
                total++; if (o_addr !== 32'h100 + 32'(4 * n)) begin bad++; $display("FAIL full_order%0d got=%h exp=%h", n, o_addr, 32'h100 + 32'(4 * n)); end
                n++;
                iy_ack_i = 1'b1;
            end
        end
        tick();
        iy_ack_i = 1'b0;
        total++; if (n !== 4) begin bad++; $display("FAIL full_issued got=%0d exp=4", n); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL full_drain got=%0d exp=0", level); end
    endtask

    task automatic test_read();
        do_reset();
        addr = 32'h20; wdata = 32'h1; be = 4'hF; rd = 1'b0; req = 1'b1;
        tick();
        addr = 32'h24; rd = 1'b1; iy_ack_i = 1'b1;
        #1;
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rd_accept_ack got=%b exp=0", ack); end
        total++; if (o_addr !== 32'h20) begin bad++; $display("FAIL rd_write_first got=%h exp=20", o_addr); end
        tick();
        req = 1'b0; rd = 1'b0; iy_ack_i = 1'b0;
        total++; if (busy !== 1'b1 || level !== 3'd1) begin bad++; $display("FAIL rd_pend got=%b %0d exp=1 1", busy, level); end
        tick();
        total++; if (o_req !== 1'b1 || o_addr !== 32'h24 || o_rd !== 1'b1) begin bad++; $display("FAIL rd_issue got=%b %h %b exp=1 24 1", o_req, o_addr, o_rd); end
        tick();
        tick();
        iy_ack_i = 1'b1; iy_rdata_i = 32'h12345678;
        #1;
        total++; if (busy !== 1'b1 || ack !== 1'b0) begin bad++; $display("FAIL rd_wait got=%b %b exp=1 0", busy, ack); end
        tick();
        iy_ack_i = 1'b0; iy_rdata_i = '0;
        total++; if (ack !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rd_done got=%b %b exp=1 0", ack, busy); end
        total++; if (rdata !== 32'h12345678) begin bad++; $display("FAIL rd_data got=%h exp=12345678", rdata); end
        tick();
        total++; if (ack !== 1'b0 || rdata !== 32'h12345678) begin bad++; $display("FAIL rd_ack_once got=%b %h exp=0 12345678", ack, rdata); end
    endtask

    task automatic test_err();
        do_reset();
        addr = 32'h30; rd = 1'b1; req = 1'b1;
        tick();
        req = 1'b0; rd = 1'b0; iy_ack_i = 1'b1; iy_err_i = 1'b1; iy_rdata_i = 32'h5555;
        tick();
        iy_ack_i = 1'b0; iy_err_i = 1'b0;
        total++; if (ack !== 1'b1 || rdata !== 32'hFFFFFFFF) begin bad++; $display("FAIL err_rd got=%b %h exp=1 ffffffff", ack, rdata); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clr got=%b exp=0", err); end
        addr = 32'h40; req = 1'b1;
        tick();
        req = 1'b0; iy_err_i = 1'b1; err_clr = 1'b1;
        tick();
        iy_err_i = 1'b0; err_clr = 1'b0;
        total++; if (err !== 1'b1 || level !== 3'd0) begin bad++; $display("FAIL err_set_wins got=%b %0d exp=1 0", err, level); end
    endtask

    task automatic test_timeout();
        int k;
        do_reset();
        addr = 32'h50; wdata = 32'hAA; rd = 1'b0; req = 1'b1;
        tick();
        addr = 32'h54; wdata = 32'hBB;
        tick();
        req = 1'b0;
        k = 1;
        repeat (4) begin tick(); k++; end
        total++; if (err !== 1'b0 || level !== 3'd2) begin bad++; $display("FAIL tmo_early got=%b %0d exp=0 2", err, level); end
        while (k < 20 && !o_req) begin tick(); k++; end
        total++; if (k < 9 || k > 11) begin bad++; $display("FAIL tmo_cycles got=%0d exp=9..11", k); end
        total++; if (o_addr !== 32'h54 || o_wdata !== 32'hBB) begin bad++; $display("FAIL tmo_next got=%h %h exp=54 bb", o_addr, o_wdata); end
        total++; if (err !== 1'b1 || level !== 3'd1) begin bad++; $display("FAIL tmo_abort got=%b %0d exp=1 1", err, level); end
        total++; if (z_err !== 1'b0 || z_level !== 3'd2 || z_req !== 1'b0 || z_addr !== 32'h50)
            begin bad++; $display("FAIL tmo0_wait got=%b %0d %b %h exp=0 2 0 50", z_err, z_level, z_req, z_addr); end
        iy_ack_i = 1'b1;
        tick();
        iy_ack_i = 1'b0;
        total++; if (level !== 3'd0) begin bad++; $display("FAIL tmo_drain got=%0d exp=0", level); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rd = 1'b0; req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr = 32'h60 + 32'(4 * i);
            tick();
        end
        req = 1'b0;
        total++; if (level !== 3'd3) begin bad++; $display("FAIL mid_level got=%0d exp=3", level); end
        addr = 32'h70; req = 1'b1; rst_n = 1'b0;
        #1;
        total++; if (ack !== 1'b0 || busy !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL mid_rst got=%b %b %0d exp=0 0 0", ack, busy, level); end
        total++; if (o_req !== 1'b0 || o_addr !== '0 || o_be !== '0) begin bad++; $display("FAIL mid_iy got=%b %h %h exp=0 0 0", o_req, o_addr, o_be); end
        req = 1'b0;
        tick();
        rst_n = 1'b1;
        iy_ack_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++; if (o_req !== 1'b0 || ack !== 1'b0) begin bad++; $display("FAIL mid_quiet%0d got=%b %b exp=0 0", c, o_req, ack); end
        end
        iy_ack_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_full();
        test_read();
        test_err();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sp3a_xyq.md
Name: sp3a_xyq

Overview:
Single-clock, parametrised successor to the 32-bit ix→iy bus connection. It keeps the same ix (initiator) and iy (target) req/ack/busy/err signalling. Writes are posted through a DEPTH-entry command queue, and reads are blocking and kept in order behind queued writes. A per-transaction timeout and a sticky error flag with explicit clear are added.

Parameters:
AW, 32, address width (1..32)
DW, 32, data width (multiple of 8); BW=DW/8 byte enables (derived localparam)
DEPTH, 4, command queue depth (power of 2, >=2)
TMO, 255, iy wait timeout in cycles (0 = timeout disabled; max 65535)

Ports:
ix_clk  in  1  clock, all logic on rising edge
ix_rst_n  in  1  asynchronous active-low reset
ix_addr  in  AW  initiator address
ix_wdata  in  DW  initiator write data
ix_be  in  BW  initiator byte enables
ix_rd  in  1  1=read, 0=write
ix_req  in  1  request, sampled when ix_busy=0
ix_busy  out  1  queue full or read outstanding
ix_ack  out  1  write accept / read completion strobe
ix_rdata  out  DW  read data, held until next read completes
ix_err  out  1  sticky error (iy_err or timeout)
ix_err_clr  in  1  clears ix_err
ix_level  out  clog2(DEPTH)+1  current queue occupancy
iy_addr  out  AW  target address
iy_wdata  out  DW  target write data
iy_be  out  BW  target byte enables
iy_rd  out  1  target read/#write
iy_req  out  1  one-cycle target request pulse
iy_busy  in  1  target not ready; blocks issue
iy_ack  in  1  target completion
iy_err  in  1  target error, terminates current transaction
iy_rdata  in  DW  target read data, valid with iy_ack

Behaviour:
- Reset (ix_rst_n=0, asynchronous):
  - Queue is emptied and the FSM goes to IDLE.
  - iy_addr, iy_wdata, iy_be, iy_rd and iy_req are all 0.
  - ix_rdata=0, ix_err=0, ix_level=0, ix_busy=0.
  - ix_ack is forced to 0 while reset is low.
- Reset mid-transaction discards all queued and in-flight commands. No ack is produced for them.
- Accept: a command is accepted on an edge where ix_req=1 and ix_busy=0. {addr,wdata,be,rd} is pushed to the queue. ix_req while ix_busy=1 is ignored; the initiator must re-present it.
- ix_busy = (level==DEPTH) | rd_pend.
- Write accept: ix_ack is combinational (ix_req & ~ix_busy & ~ix_rd), asserted in the accept cycle.
- Read accept: no ack at accept. rd_pend is set on the accept edge, so ix_busy=1 from the next cycle until the read's completion ack.
- Issue FSM states:
  - IDLE: when queue non-empty and iy_busy=0, on the next edge register the head entry onto iy_*, set iy_req=1 and go to WAIT. iy_busy=1 holds IDLE.
  - WAIT: iy_req=1 for the first WAIT cycle only. The iy_ack, iy_err and timeout checks below are evaluated in every WAIT cycle, including the iy_req cycle.
    - iy_ack=1 and iy_err=0: pop the queue. If iy_rd, latch iy_rdata into ix_rdata. Go to IDLE.
    - iy_err=1 (takes priority over iy_ack): pop the queue and set ix_err. If iy_rd, load ix_rdata with all ones. Go to IDLE.
    - Timeout: a counter is cleared on entering WAIT and increments each WAIT cycle. When it reaches TMO (TMO>0), the transaction is treated exactly as iy_err.
- Read completion: ix_ack pulses for exactly one cycle, the cycle after the completing edge. rd_pend clears on that same edge, so ix_busy falls with the ack.
- IDLE drive: iy_req=0 and iy_be=0. iy_addr, iy_wdata and iy_rd hold their last values.
- Latency: with an empty queue and iy_busy=0, iy_req is high in the cycle after the accept cycle. Back-to-back queued commands are issued with at most one IDLE cycle between them.
- Queue: circular, with read and write pointers of clog2(DEPTH) bits wrapping modulo DEPTH.
  - A push at full cannot occur, because it is blocked by ix_busy.
  - Push and pop on the same edge leave ix_level unchanged.
  - ix_level is registered and reflects the edge just taken.
- Ordering: strictly FIFO. A read is issued only after all earlier writes complete.
- Error clear: ix_err_clr=1 clears ix_err on the next edge. If a new error occurs on the same edge, the set wins.

Test Plan:
- Reset with ix_req=1 held → ix_ack=0, ix_busy=0, all iy_* 0. Release reset and write 0x10/0xA5A5A5A5/be=F → ix_ack in the accept cycle; iy_req high next cycle with iy_addr=0x10, iy_wdata=0xA5A5A5A5; ix_level 1 → 0 after iy_ack.
- iy_busy=1, DEPTH=4, post 4 writes → ix_level=4, ix_busy=1, fifth ix_req ignored. Release iy_busy → 4 iy_req pulses with addresses in order; ix_busy drops after the first pop.
- Write 0x20 then read 0x24, target returns 0x12345678 with iy_ack on the 3rd WAIT cycle → read issued after the write's ack; ix_rdata=0x12345678; single-cycle ix_ack; ix_busy=1 from read accept until that ack.
- Read with iy_err=1 together with iy_ack → ix_rdata=0xFFFFFFFF, ix_ack pulse, ix_err=1. ix_err_clr → ix_err=0 next cycle. Clear on the same edge as a new error → ix_err stays 1.
- TMO=8, target never acks a write → transaction aborted at count 8, ix_err=1, queue popped, next command issued. TMO=0 → waits indefinitely.
- Assert ix_rst_n low while in WAIT with 3 entries queued → immediate return to reset values; no ix_ack and no further iy_req after release.
